counter_4bit: RTL and testbench



---
 rtl/counter_pkg.sv | 8 +
 rtl/counter_tff.sv | 19 +
 rtl/counter_4bit.sv | 63 ++++++
 tb/tb_counter_4bit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the 4-bit free-running counter.
package counter_pkg;

  localparam int unsigned            CNT_W   = 4;
  localparam logic [CNT_W-1:0]       CNT_MAX = 4'hF;
  localparam logic [CNT_W-1:0]       CNT_RST = 4'h0;

endpackage

// File: rtl/counter_tff.sv
// Toggle flop with asynchronous active-low reset; one bit of the counter.
module counter_tff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/counter_4bit.sv
// Free-running 4-bit synchronous up-counter built from toggle flops.
// Optional registered terminal-count output enabled by COUNTER_TC_EN.
module counter_4bit
  import counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3
`ifdef COUNTER_TC_EN
  ,
  output logic tc
`endif
);

  logic [1:0]       rst_sync;
  logic             rst_i;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] t;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_i = rst_sync[1];

  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    t[1] = cnt[0];
    t[2] = cnt[0] & cnt[1];
    t[3] = cnt[0] & cnt[1] & cnt[2];
  end

  counter_tff #(.RST_VAL(CNT_RST[0])) u_tff0 (.clk(clk), .rst_n(rst_i), .t(t[0]), .q(cnt[0]));
  counter_tff #(.RST_VAL(CNT_RST[1])) u_tff1 (.clk(clk), .rst_n(rst_i), .t(t[1]), .q(cnt[1]));
  counter_tff #(.RST_VAL(CNT_RST[2])) u_tff2 (.clk(clk), .rst_n(rst_i), .t(t[2]), .q(cnt[2]));
  counter_tff #(.RST_VAL(CNT_RST[3])) u_tff3 (.clk(clk), .rst_n(rst_i), .t(t[3]), .q(cnt[3]));

  assign q0 = cnt[0];
  assign q1 = cnt[1];
  assign q2 = cnt[2];
  assign q3 = cnt[3];

`ifdef COUNTER_TC_EN
  // Registered look-ahead: set on the edge that moves the count to CNT_MAX.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      tc <= 1'b0;
    end else begin
      tc <= (cnt == CNT_MAX - 1'b1);
    end
  end
`endif

endmodule

// File: tb/tb_counter_4bit.sv
// Scoreboard bench for counter_4bit: stimulus pushes expectations, a monitor pops and compares.
module tb_counter_4bit;

  typedef struct {
    string       name;
    bit          is_per;
    int unsigned idx;
    logic [3:0]  cnt;
    logic        tc;
    realtime     per;
    realtime     high;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic q0, q1, q2, q3;
`ifdef COUNTER_TC_EN
  logic tc;
`endif

  counter_4bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q0   (q0),
    .q1   (q1),
    .q2   (q2),
    .q3   (q3)
`ifdef COUNTER_TC_EN
    ,
    .tc   (tc)
`endif
  );

  always #10 clk = ~clk;

  exp_t       sb[$];
  event       ev_push;
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model    = 4'h0;
  logic [3:0] qv;
  logic [3:0] qprev    = 4'h0;
  realtime    rise_t[4];
  realtime    prev_rise[4];
  realtime    fall_t[4];

  assign qv = {q3, q2, q1, q0};

  // Edge-time recorder for the divider measurements.
  always @(qv) begin
    for (int k = 0; k < 4; k++) begin
      if (qv[k] !== qprev[k]) begin
        if (qv[k] === 1'b1) begin
          prev_rise[k] = rise_t[k];
          rise_t[k]    = $realtime;
        end else begin
          fall_t[k] = $realtime;
        end
      end
    end
    qprev = qv;
  end

  task automatic push_cnt(input string name);
    exp_t e;
    e.name   = name;
    e.is_per = 1'b0;
    e.idx    = 0;
    e.cnt    = model;
    e.tc     = (model == 4'hF);
    e.per    = 0.0;
    e.high   = 0.0;
    sb.push_back(e);
    -> ev_push;
  endtask

  task automatic push_per(input string name, input int unsigned idx, input realtime per);
    exp_t e;
    e.name   = name;
    e.is_per = 1'b1;
    e.idx    = idx;
    e.cnt    = 4'h0;
    e.tc     = 1'b0;
    e.per    = per;
    e.high   = per / 2.0;
    sb.push_back(e);
    -> ev_push;
  endtask

  // Monitor: drains the scoreboard and compares against the live DUT or measurements.
  initial begin
    exp_t    e;
    realtime a_per, a_high;
    forever begin
      while (sb.size() == 0) @(ev_push);
      e = sb.pop_front();
      if (!e.is_per) begin
        checks++;
        if (qv !== e.cnt) begin
          failures++;
          $display("FAIL %s t=%0t: q3..q0 actual=%b expected=%b", e.name, $time, qv, e.cnt);
        end
`ifdef COUNTER_TC_EN
        checks++;
        if (tc !== e.tc) begin
          failures++;
          $display("FAIL %s_tc t=%0t: tc actual=%b expected=%b", e.name, $time, tc, e.tc);
        end
`endif
      end else begin
        a_per  = rise_t[e.idx] - prev_rise[e.idx];
        a_high = (fall_t[e.idx] > rise_t[e.idx]) ? fall_t[e.idx] - rise_t[e.idx]
                                                 : fall_t[e.idx] - prev_rise[e.idx];
        checks++;
        if (a_per != e.per) begin
          failures++;
          $display("FAIL %s_period bit=%0d: actual=%0t expected=%0t", e.name, e.idx, a_per, e.per);
        end
        checks++;
        if (a_high != e.high) begin
          failures++;
          $display("FAIL %s_high bit=%0d: actual=%0t expected=%0t", e.name, e.idx, a_high, e.high);
        end
      end
    end
  end

  initial begin
    string nm;
    rst_n = 1'b0;
    model = 4'h0;
    repeat (3) begin
      @(negedge clk);
      push_cnt("por_hold");
    end

    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      push_cnt("por_sync_hold");
    end

    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      model = model + 4'h1;
      nm = (i % 16 == 0) ? "wrap" : "count";
      push_cnt(nm);
    end

    push_per("div_q0", 0, 40.0);
    push_per("div_q1", 1, 80.0);
    push_per("div_q2", 2, 160.0);
    push_per("div_q3", 3, 320.0);

    repeat (5) begin
      @(negedge clk);
      model = model + 4'h1;
      push_cnt("pre_reset_count");
    end

    // Midway between edges at C=0101: reset must act without a clock edge.
    rst_n = 1'b0;
    model = 4'h0;
    #1;
    push_cnt("async_reset");
    repeat (2) begin
      @(negedge clk);
      push_cnt("reset_held");
    end

    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      push_cnt("restart_sync_hold");
    end
    repeat (3) begin
      @(negedge clk);
      model = model + 4'h1;
      push_cnt("restart_count");
    end

    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
